// File: rtl/lif_neuron_if.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_if
//  Description : Weight-stream handshake, timestep strobe and spike/potential
//                status bundle between the neuron core and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_if #(
    parameter int WIDTH = 16
);
    logic                    en;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_weight;
    logic                    in_ready;
    logic                    step;
    logic                    spike;
    logic signed [WIDTH-1:0] vmem;
    logic                    refractory;
    logic [15:0]             spike_cnt;

    // Upstream/test side: drives weights and strobes, observes the neuron.
    modport master (
        output en, in_valid, in_weight, step,
        input  in_ready, spike, vmem, refractory, spike_cnt
    );

    // Neuron core side.
    modport slave (
        input  en, in_valid, in_weight, step,
        output in_ready, spike, vmem, refractory, spike_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Leaky integrate-and-fire neuron. Integrates signed weights
//                into a saturating membrane potential, applies a shift leak
//                and threshold test on each timestep, fires a one-cycle spike
//                and then sits out a refractory period counted in timesteps.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron #(
    parameter int WIDTH      = 16,
    parameter int THRESH     = 1000,
    parameter int LEAK_SHIFT = 4,
    parameter int V_RESET    = 0,
    parameter int REFRAC     = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lif_neuron_if.slave   nrn
);

    localparam logic [1:0] c_S_ACCUM  = 2'd0;
    localparam logic [1:0] c_S_FIRE   = 2'd1;
    localparam logic [1:0] c_S_REFRAC = 2'd2;

    localparam logic signed [WIDTH-1:0] c_THRESH  = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] c_V_RESET = WIDTH'(V_RESET);
    localparam logic signed [WIDTH-1:0] c_V_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_V_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0]              c_REFRAC  = 8'(REFRAC);
    localparam logic                    c_HAS_REF = (REFRAC > 0);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic signed [WIDTH-1:0] r_vmem;
    logic                    r_spike;
    logic                    r_refractory;
    logic [15:0]             r_spike_cnt;
    logic [7:0]              r_rcnt;

    logic                    w_ready;
    logic                    w_xfer;
    logic signed [WIDTH-1:0] w_weight;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH-1:0] w_v1;
    logic signed [WIDTH-1:0] w_leak;
    logic signed [WIDTH-1:0] w_v2;
    logic                    w_cross;

    assign w_ready  = nrn.en && (r_state != c_S_FIRE);
    assign w_xfer   = nrn.in_valid && w_ready;
    assign w_weight = w_xfer ? nrn.in_weight : '0;

    // Sum one bit wider, then clamp when the top two bits disagree.
    assign w_sum = {r_vmem[WIDTH-1], r_vmem} + {w_weight[WIDTH-1], w_weight};
    assign w_v1  = (w_sum[WIDTH] != w_sum[WIDTH-1])
                   ? (w_sum[WIDTH] ? c_V_MIN : c_V_MAX)
                   : w_sum[WIDTH-1:0];

    // Leak never overflows: the subtracted term has the same sign and a
    // smaller magnitude than v1.
    assign w_leak  = w_v1 >>> LEAK_SHIFT;
    assign w_v2    = w_v1 - w_leak;
    assign w_cross = (w_v2 >= c_THRESH);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; everything freezes while disabled.
    always_comb begin
        w_state_nxt = r_state;
        if (nrn.en) begin
            case (r_state)
                c_S_ACCUM: begin
                    if (nrn.step && w_cross) begin
                        w_state_nxt = c_S_FIRE;
                    end
                end
                c_S_FIRE: begin
                    w_state_nxt = c_HAS_REF ? c_S_REFRAC : c_S_ACCUM;
                end
                c_S_REFRAC: begin
                    if (nrn.step && (r_rcnt <= 8'd1)) begin
                        w_state_nxt = c_S_ACCUM;
                    end
                end
                default: begin
                    w_state_nxt = c_S_ACCUM;
                end
            endcase
        end
    end

    // Membrane potential, spike pulse, spike counter and refractory timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vmem       <= c_V_RESET;
            r_spike      <= 1'b0;
            r_refractory <= 1'b0;
            r_spike_cnt  <= 16'd0;
            r_rcnt       <= 8'd0;
        end else if (nrn.en) begin
            case (r_state)
                c_S_ACCUM: begin
                    if (nrn.step) begin
                        if (w_cross) begin
                            r_vmem      <= c_V_RESET;
                            r_spike     <= 1'b1;
                            r_spike_cnt <= r_spike_cnt + 16'd1;
                            r_rcnt      <= c_REFRAC;
                        end else begin
                            r_vmem <= w_v2;
                        end
                    end else if (w_xfer) begin
                        r_vmem <= w_v1;
                    end
                end
                c_S_FIRE: begin
                    r_spike      <= 1'b0;
                    r_refractory <= c_HAS_REF;
                end
                c_S_REFRAC: begin
                    // Weights arriving here are accepted but dropped.
                    if (nrn.step) begin
                        if (r_rcnt <= 8'd1) begin
                            r_rcnt       <= 8'd0;
                            r_refractory <= 1'b0;
                        end else begin
                            r_rcnt <= r_rcnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_spike      <= 1'b0;
                    r_refractory <= 1'b0;
                end
            endcase
        end
    end

    assign nrn.in_ready   = w_ready;
    assign nrn.spike      = r_spike;
    assign nrn.vmem       = r_vmem;
    assign nrn.refractory = r_refractory;
    assign nrn.spike_cnt  = r_spike_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron
//  Description : Directed, table-driven bench for lif_neuron with
//                hand-computed expected values and a few sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

    typedef struct {
        logic rst;
        logic en;
        logic valid;
        int   weight;
        logic step;
        int   e_vmem;
        logic e_spike;
        logic e_ready;
        logic e_refr;
        int   e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    lif_neuron_if #(.WIDTH(16)) ifc ();

    lif_neuron #(
        .WIDTH      (16),
        .THRESH     (1000),
        .LEAK_SHIFT (4),
        .V_RESET    (0),
        .REFRAC     (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .nrn (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic v, input int w,
                       input logic s, input int ev, input logic esp,
                       input logic erdy, input logic erf, input int ec);
        vec_t t;
        t.rst = r; t.en = e; t.valid = v; t.weight = w; t.step = s;
        t.e_vmem = ev; t.e_spike = esp; t.e_ready = erdy; t.e_refr = erf;
        t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic e, input logic v,
                         input int w, input logic s);
        rst           = r;
        ifc.en        = e;
        ifc.in_valid  = v;
        ifc.in_weight = 16'(w);
        ifc.step      = s;
    endtask

    initial begin
        int k;
        int steps;
        bit got;
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);

        //   rst en vld weight  stp  vmem  spk rdy ref cnt
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);   // reset state
        add(0, 1, 1,    500, 0,    500, 0, 1, 0, 0);   // integrate
        add(0, 1, 1,    300, 0,    800, 0, 1, 0, 0);
        add(0, 1, 0,      0, 1,    750, 0, 1, 0, 0);   // leak
        add(0, 1, 0,      0, 1,    704, 0, 1, 0, 0);
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);
        add(0, 1, 1,    600, 0,    600, 0, 1, 0, 0);
        add(0, 1, 1,    600, 0,   1200, 0, 1, 0, 0);
        add(0, 1, 0,      0, 1,      0, 1, 0, 0, 1);   // 1125 fires
        add(0, 1, 1,     77, 1,      0, 0, 1, 1, 1);   // FIRE ignores step
        add(0, 1, 1,   5000, 0,      0, 0, 1, 1, 1);   // dropped in REFRAC
        add(0, 1, 0,      0, 1,      0, 0, 1, 1, 1);
        add(0, 1, 0,      0, 1,      0, 0, 1, 0, 1);   // refractory ends
        add(0, 1, 1,    100, 0,    100, 0, 1, 0, 1);
        add(0, 1, 1,    800, 0,    900, 0, 1, 0, 1);
        add(0, 1, 1,    200, 1,      0, 1, 0, 0, 2);   // 1100 -> 1032 fires
        add(0, 1, 0,      0, 0,      0, 0, 1, 1, 2);
        add(0, 1, 0,      0, 1,      0, 0, 1, 1, 2);
        add(0, 1, 0,      0, 1,      0, 0, 1, 0, 2);
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);
        add(0, 1, 1,  30000, 0,  30000, 0, 1, 0, 0);   // positive clamp
        add(0, 1, 1,  30000, 0,  32767, 0, 1, 0, 0);
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);
        add(0, 1, 1, -20000, 0, -20000, 0, 1, 0, 0);   // negative clamp
        add(0, 1, 1, -20000, 0, -32768, 0, 1, 0, 0);
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);
        add(0, 1, 1,   -100, 1,    -93, 0, 1, 0, 0);   // negative leak
        add(0, 1, 1,    100, 0,      7, 0, 1, 0, 0);
        add(0, 0, 1,    500, 1,      7, 0, 0, 0, 0);   // disabled: hold
        add(1, 1, 0,      0, 0,      0, 0, 1, 0, 0);
        add(0, 1, 1,   2000, 0,   2000, 0, 1, 0, 0);
        add(0, 1, 0,      0, 1,      0, 1, 0, 0, 1);   // 1875 fires
        add(0, 0, 0,      0, 0,      0, 1, 0, 0, 1);   // spike held while off
        add(0, 0, 1,     50, 1,      0, 1, 0, 0, 1);
        add(0, 1, 0,      0, 0,      0, 0, 1, 1, 1);
        add(0, 1, 0,      0, 1,      0, 0, 1, 1, 1);
        add(0, 1, 0,      0, 1,      0, 0, 1, 0, 1);
        add(0, 1, 1,   2000, 0,   2000, 0, 1, 0, 1);
        add(0, 1, 0,      0, 1,      0, 1, 0, 0, 2);
        add(0, 1, 0,      0, 0,      0, 0, 1, 1, 2);
        add(0, 1, 0,      0, 1,      0, 0, 1, 1, 2);
        add(0, 1, 0,      0, 1,      0, 0, 1, 0, 2);
        add(0, 1, 1,   2000, 0,   2000, 0, 1, 0, 2);
        add(0, 1, 0,      0, 1,      0, 1, 0, 0, 3);
        add(0, 1, 0,      0, 0,      0, 0, 1, 1, 3);   // now REFRAC, cnt=3
        add(1, 1, 1,    400, 1,      0, 0, 1, 0, 0);   // reset mid-REFRAC
        add(0, 1, 1,    100, 0,    100, 0, 1, 0, 0);   // back in ACCUM

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].weight,
                  vecs[i].step);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.vmem", i), int'($signed(ifc.vmem)), vecs[i].e_vmem);
            check($sformatf("v%0d.spike", i), int'(ifc.spike), int'(vecs[i].e_spike));
            check($sformatf("v%0d.in_ready", i), int'(ifc.in_ready), int'(vecs[i].e_ready));
            check($sformatf("v%0d.refractory", i), int'(ifc.refractory), int'(vecs[i].e_refr));
            check($sformatf("v%0d.spike_cnt", i), int'(ifc.spike_cnt), vecs[i].e_cnt);
        end

        // in_ready follows en combinationally within the cycle.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check("ready_drops_with_en", int'(ifc.in_ready), 0);
        ifc.en = 1'b1;
        #1;
        check("ready_rises_with_en", int'(ifc.in_ready), 1);

        // Weight 300 with a step every cycle:
        // 282, 546, 794, then 1094-68=1026 fires on the fourth step.
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 300, 1'b1);
        steps = 0;
        got   = 1'b0;
        k     = 0;
        while (!got && k < 10) begin
            @(posedge clk);
            #1;
            steps++;
            k++;
            if (ifc.spike) got = 1'b1;
            else if (steps == 3) check("ramp_v3", int'($signed(ifc.vmem)), 794);
        end
        check("ramp_spike_seen", int'(got), 1);
        check("ramp_steps_to_spike", steps, 4);
        // Still strobing: FIRE ignores it, first REFRAC step keeps refractory.
        @(posedge clk);
        #1;
        check("ramp_refr_entered", int'(ifc.refractory), 1);
        @(posedge clk);
        #1;
        check("ramp_refr_held", int'(ifc.refractory), 1);
        @(posedge clk);
        #1;
        check("ramp_refr_done", int'(ifc.refractory), 0);
        check("ramp_vmem_after", int'($signed(ifc.vmem)), 0);

        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
